sobel_frame_source: RTL and testbench

SOBEL_FRAME_SOURCE -- requirements
Module: sobel_frame_source

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_skid_fifo.sv | 56 +++++
 rtl/sobel_frame_source.sv | 139 +++++++++++++
 tb/tb_sobel_frame_source.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame path.
// Holds the frame-source state enum, channel width and the test-pattern step.
package sobel_pkg;

  localparam int PIXEL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Adjacent pattern pixels differ by 16, wrapping mod 256.
  function automatic logic [PIXEL_BITS-1:0] pattern_step(input logic [PIXEL_BITS-1:0] b);
    return b + PIXEL_BITS'(16);
  endfunction

endpackage

// File: rtl/sobel_skid_fifo.sv
// Two-entry FIFO; head is visible the cycle after a push.
// Push is dropped only when full without a simultaneous pop (caller credit-limits).
module sobel_skid_fifo #(
  parameter int W_P = 9
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           push_i,
  input  logic [W_P-1:0] push_dat_i,
  input  logic           pop_i,
  output logic           vld_o,
  output logic [W_P-1:0] dat_o,
  output logic [1:0]     count_o
);

  logic [W_P-1:0] mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic [1:0]     cnt_d;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign vld_o   = (cnt_q != 2'd0);
  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/sobel_frame_source.sv
// Streams one raster frame from frame memory (or a test pattern with SOBEL_FRAME_SOURCE_PATTERN_EN).
// Latency start->first valid 3 cycles; 1 pixel/cycle; reads throttled so FIFO+in-flight <= 2.
module sobel_frame_source import sobel_pkg::*; #(
  parameter int WIDTH_P    = 10,
  parameter int HEIGHT_P   = 10,
  parameter int CHANNELS_P = 1,
  localparam int PW = CHANNELS_P * PIXEL_BITS,
  localparam int AW = $clog2(WIDTH_P * HEIGHT_P)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
  input  logic          pattern_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [PW-1:0] rd_data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [PW-1:0] pixel_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH_P * HEIGHT_P - 1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          inflight_q;
  logic          infl_last_q;

  logic          fifo_vld;
  logic [PW:0]   head_dat;
  logic [1:0]    fifo_cnt;
  logic [1:0]    occ;
  logic          head_last;
  logic          pop;
  logic          issue;
  logic [PW-1:0] push_pix;

  assign head_last = head_dat[PW];
  assign pop       = fifo_vld && ready_i;
  assign occ       = fifo_cnt + {1'b0, inflight_q};
  // A same-cycle pop frees the slot the new read will land in two cycles later.
  assign issue     = (state_q == RUN) && ((occ < 2'd2) || pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      inflight_q  <= issue;
      infl_last_q <= issue && (addr_q == LAST_ADDR);
      unique case (state_q)
        IDLE: if (start_i) state_q <= RUN;
        RUN: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        DRAIN: if (pop && head_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
  localparam int XW = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH_P - 1);

  logic                  pat_q;
  logic [XW-1:0]         col_q;
  logic [PIXEL_BITS-1:0] row_byte_q;
  logic [PIXEL_BITS-1:0] cur_byte_q;
  logic [PIXEL_BITS-1:0] pat_byte_q;

  // Pattern value tracked incrementally so no divider is needed for x/y.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pat_q      <= 1'b0;
      col_q      <= '0;
      row_byte_q <= '0;
      cur_byte_q <= '0;
      pat_byte_q <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      pat_q      <= pattern_i;
      col_q      <= '0;
      row_byte_q <= '0;
      cur_byte_q <= '0;
    end else if (issue) begin
      pat_byte_q <= cur_byte_q;
      if (col_q == COL_LAST) begin
        col_q      <= '0;
        row_byte_q <= pattern_step(row_byte_q);
        cur_byte_q <= pattern_step(row_byte_q);
      end else begin
        col_q      <= col_q + XW'(1);
        cur_byte_q <= pattern_step(cur_byte_q);
      end
    end
  end

  assign rd_en_o  = issue && !pat_q;
  assign push_pix = pat_q ? {CHANNELS_P{pat_byte_q}} : rd_data_i;
`else
  assign rd_en_o  = issue;
  assign push_pix = rd_data_i;
`endif

  sobel_skid_fifo #(
    .W_P(PW + 1)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (inflight_q),
    .push_dat_i({infl_last_q, push_pix}),
    .pop_i     (pop),
    .vld_o     (fifo_vld),
    .dat_o     (head_dat),
    .count_o   (fifo_cnt)
  );

  assign rd_addr_o = addr_q;
  assign busy_o    = (state_q != IDLE);
  assign valid_o   = fifo_vld;
  assign pixel_o   = head_dat[PW-1:0];
  assign last_o    = fifo_vld && head_last;
  assign done_o    = (state_q == DRAIN) && pop && head_last;

endmodule

// File: tb/tb_sobel_frame_source.sv
// Directed bench for sobel_frame_source at 4x3x1 with mem[a] = a + 8'h10.
// A negedge monitor scoreboards read order, pixel order, stall hold and occupancy.
module tb_sobel_frame_source;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_en_o;
  logic [3:0] rd_addr_o;
  logic [7:0] rd_data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] pixel_o;
  logic       last_o;
`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
  logic       pattern_i;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b1;

  always #5 clk = ~clk;

  sobel_frame_source #(
    .WIDTH_P   (4),
    .HEIGHT_P  (3),
    .CHANNELS_P(1)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .start_i  (start_i),
`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
    .pattern_i(pattern_i),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rd_en_o  (rd_en_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .pixel_o  (pixel_o),
    .last_o   (last_o)
  );

  // Frame memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= 8'(rd_addr_o) + 8'h10;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  int         exp_idx   = 0;
  int         exp_addr  = 0;
  int         outst     = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_pix;
  logic       prev_last;

  always @(negedge clk) begin
    if (!mon_en || reset_i) begin
      exp_idx    = 0;
      exp_addr   = 0;
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", valid_o, 1);
        check("hold_pix", pixel_o, prev_pix);
        check("hold_last", last_o, prev_last);
      end
      if (outst > 2) check("outstanding", outst, 2);
      if (valid_o && ready_i) begin
        check("pix", pixel_o, 8'h10 + exp_idx);
        check("last", last_o, exp_idx == 11);
        check("done", done_o, exp_idx == 11);
        exp_idx = (exp_idx == 11) ? 0 : exp_idx + 1;
        outst--;
      end else if (done_o) begin
        check("done_no_pop", done_o, 0);
      end
      if (rd_en_o) begin
        check("rd_addr", rd_addr_o, exp_addr);
        exp_addr = (exp_addr == 11) ? 0 : exp_addr + 1;
        outst++;
      end
      prev_stall = valid_o && !ready_i;
      prev_pix   = pixel_o;
      prev_last  = last_o;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: ready toggles 1010...; 2: ready low through cycle 20
  task automatic run_frame(input int mode, output int npix, output int ndone, output int nrd_early);
    npix = 0;
    ndone = 0;
    nrd_early = 0;
    for (int c = 0; c < 200; c++) begin
      start_i = (c == 0);
      case (mode)
        1:       ready_i = (c % 2 == 0);
        2:       ready_i = (c > 20);
        default: ready_i = 1'b1;
      endcase
      @(negedge clk);
      if (valid_o && ready_i) npix++;
      if (rd_en_o && c <= 20) nrd_early++;
      if (done_o) begin
        ndone++;
        next_cycle();
        break;
      end
      next_cycle();
    end
    start_i = 1'b0;
  endtask

  int npix, ndone, nrd;

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    ready_i = 1'b0;
`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
    pattern_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rden", rd_en_o, 0);
    check("rst_vld", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_addr", rd_addr_o, 0);
    check("rst_pix", pixel_o, 0);
    next_cycle();
    reset_i = 1'b0;

    // Start pulse, ready high: exact cycle timing
    start_i = 1'b1;
    ready_i = 1'b1;
    npix = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      check("A_vld", valid_o, (c >= 3) && (c <= 14));
      check("A_done", done_o, c == 14);
      check("A_rden", rd_en_o, (c >= 1) && (c <= 12));
      check("A_busy", busy_o, (c >= 1) && (c <= 14));
      if (c == 1) check("A_addr0", rd_addr_o, 0);
      if (c == 3) check("A_pix0", pixel_o, 8'h10);
      if (c == 14) check("A_pix11", pixel_o, 8'h1B);
      if (valid_o && ready_i) npix++;
      next_cycle();
      start_i = 1'b0;
    end
    check("A_npix", npix, 12);

    // ready toggling
    run_frame(1, npix, ndone, nrd);
    check("B_npix", npix, 12);
    check("B_done", ndone, 1);

    // ready held low for 20 cycles
    run_frame(2, npix, ndone, nrd);
    check("C_early_reads", nrd, 2);
    check("C_npix", npix, 12);
    check("C_done", ndone, 1);

    // reset mid-frame at cycle 6
    start_i = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      start_i = 1'b0;
    end
    reset_i = 1'b1;
    #1;
    check("D_busy", busy_o, 0);
    check("D_done", done_o, 0);
    check("D_rden", rd_en_o, 0);
    check("D_vld", valid_o, 0);
    check("D_last", last_o, 0);
    check("D_addr", rd_addr_o, 0);
    check("D_pix", pixel_o, 0);
    next_cycle();
    reset_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("D_idle_done", done_o, 0);
      check("D_idle_vld", valid_o, 0);
      check("D_idle_busy", busy_o, 0);
      next_cycle();
    end
    run_frame(0, npix, ndone, nrd);
    check("D_npix", npix, 12);
    check("D_done_after", ndone, 1);

    // start held high: back-to-back frames
    start_i = 1'b1;
    ready_i = 1'b1;
    ndone = 0;
    for (int c = 0; c < 33; c++) begin
      if (c == 30) start_i = 1'b0;
      @(negedge clk);
      if (done_o) ndone++;
      check("E_done", done_o, (c == 14) || (c == 29));
      if (c == 15) check("E_idle_gap", busy_o, 0);
      if (c == 16) begin
        check("E_rden2", rd_en_o, 1);
        check("E_addr2", rd_addr_o, 0);
      end
      if (c >= 31) check("E_stop", busy_o, 0);
      next_cycle();
    end
    check("E_ndone", ndone, 2);

`ifdef SOBEL_FRAME_SOURCE_PATTERN_EN
    begin
      logic [7:0] pix [12];
      mon_en    = 1'b0;
      pattern_i = 1'b1;
      start_i   = 1'b1;
      ready_i   = 1'b1;
      npix = 0;
      nrd  = 0;
      for (int c = 0; c < 17; c++) begin
        @(negedge clk);
        if (rd_en_o) nrd++;
        check("P_vld", valid_o, (c >= 3) && (c <= 14));
        if (valid_o && ready_i && npix < 12) begin
          pix[npix] = pixel_o;
          npix++;
        end
        next_cycle();
        start_i   = 1'b0;
        pattern_i = 1'b0;
      end
      check("P_rden", nrd, 0);
      check("P_npix", npix, 12);
      check("P_x0y0", pix[0], 8'h00);
      check("P_x3y0", pix[3], 8'h30);
      check("P_x1y1", pix[5], 8'h20);
      check("P_x3y2", pix[11], 8'h50);
      mon_en = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
